// File: rtl/lcd_bus_arbiter.sv
// Sequences and shares the 8-bit character-LCD write bus between two requesters.
// Latency: a granted byte appears on lcd_data/lcd_rs the cycle after its handshake; E rises SETUP_CYC cycles later.
// Backpressure: reqN_ready is combinational and high only in IDLE after init; nothing is queued while busy.
module lcd_bus_arbiter #(
    parameter int PWRON_CYC     = 2000000,
    parameter int SETUP_CYC     = 4,
    parameter int E_HIGH_CYC    = 12,
    parameter int HOLD_CYC      = 4,
    parameter int CMD_WAIT_CYC  = 2000,
    parameter int LONG_WAIT_CYC = 80000,
    parameter int CNT_W         = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] lcd_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       init_done,
    output logic       busy
);

    // Every timed phase loads N-1 on entry and leaves when the counter reaches
    // zero, so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] PWRON_LD = CNT_W'(PWRON_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);

    // Index of the last init ROM entry; its WAIT completes initialisation.
    localparam logic [2:0] INIT_LAST = 3'd4;

    typedef enum logic [2:0] {
        ST_PWRON,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       init_idx_q;
    logic             init_done_q;
    logic             prio_q;
    logic             lcd_e_q;
    logic             lcd_rs_q;
    logic [7:0]       lcd_data_q;

    logic             cnt_zero;
    logic             idle_ok;
    logic             gnt0;
    logic             gnt1;
    logic [2:0]       init_idx_d;

    // Fixed power-up programming: 8-bit bus, 2 lines, display on, entry
    // mode increment, clear, cursor home to DDRAM 0.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h38;
            3'd1:    b = 8'h0C;
            3'd2:    b = 8'h06;
            3'd3:    b = 8'h01;
            3'd4:    b = 8'h80;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Clear display and return home need the controller's long execution time;
    // everything else, including any data write, uses the normal wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return (!rs) && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
    endfunction

    assign cnt_zero   = (cnt_q == '0);
    assign idle_ok    = (state_q == ST_IDLE) && init_done_q;
    assign init_idx_d = init_idx_q + 3'd1;

    // Round-robin grant: the priority holder wins a tie, a lone requester
    // always wins, and no grant is possible outside post-init IDLE.
    always_comb begin
        gnt0 = idle_ok && req0_valid && (!prio_q || !req1_valid);
        gnt1 = idle_ok && req1_valid && ( prio_q || !req0_valid);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign lcd_data   = lcd_data_q;
    assign lcd_e      = lcd_e_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign init_done  = init_done_q;
    assign busy       = !idle_ok;

    // Bus sequencer: power-on wait, init ROM playback, then one granted byte
    // at a time through setup / E-high / hold / execution-wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PWRON;
            cnt_q       <= PWRON_LD;
            init_idx_q  <= 3'd0;
            init_done_q <= 1'b0;
            prio_q      <= 1'b0;
            lcd_e_q     <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= 8'h00;
        end else begin
            case (state_q)
                ST_PWRON: begin
                    if (cnt_zero) begin
                        init_idx_q <= 3'd0;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= init_rom(3'd0);
                        cnt_q      <= SETUP_LD;
                        state_q    <= ST_SETUP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_SETUP: begin
                    if (cnt_zero) begin
                        lcd_e_q <= 1'b1;
                        cnt_q   <= EHIGH_LD;
                        state_q <= ST_EHIGH;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_EHIGH: begin
                    if (cnt_zero) begin
                        lcd_e_q <= 1'b0;
                        cnt_q   <= HOLD_LD;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (cnt_zero) begin
                        // Wait length depends on the byte still held on the pins.
                        cnt_q   <= is_long_cmd(lcd_rs_q, lcd_data_q) ? LONG_LD : CMD_LD;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_WAIT: begin
                    if (cnt_zero) begin
                        if (init_done_q) begin
                            state_q <= ST_IDLE;
                        end else if (init_idx_q == INIT_LAST) begin
                            init_done_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            init_idx_q <= init_idx_d;
                            lcd_rs_q   <= 1'b0;
                            lcd_data_q <= init_rom(init_idx_d);
                            cnt_q      <= SETUP_LD;
                            state_q    <= ST_SETUP;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_IDLE: begin
                    // Pins keep the last byte until a new grant replaces it.
                    if (gnt0) begin
                        lcd_rs_q   <= req0_rs;
                        lcd_data_q <= req0_data;
                        prio_q     <= 1'b1;
                        cnt_q      <= SETUP_LD;
                        state_q    <= ST_SETUP;
                    end else if (gnt1) begin
                        lcd_rs_q   <= req1_rs;
                        lcd_data_q <= req1_data;
                        prio_q     <= 1'b0;
                        cnt_q      <= SETUP_LD;
                        state_q    <= ST_SETUP;
                    end
                end

                default: begin
                    lcd_e_q <= 1'b0;
                    cnt_q   <= PWRON_LD;
                    state_q <= ST_PWRON;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with short timing parameters.
// Inputs change at the falling edge; outputs are sampled at the falling edge.
// Each scenario task carries its own hand-computed expectations.
module tb_lcd_bus_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic       req0_rs;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic       req1_rs;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [7:0] lcd_data;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       init_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] init_exp [5] = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};
    int         rise_exp [5] = '{12, 24, 36, 48, 75};

    lcd_bus_arbiter #(
        .PWRON_CYC     (10),
        .SETUP_CYC     (2),
        .E_HIGH_CYC    (3),
        .HOLD_CYC      (2),
        .CMD_WAIT_CYC  (5),
        .LONG_WAIT_CYC (20),
        .CNT_W         (22)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .lcd_data   (lcd_data),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .init_done  (init_done),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    // Bounded wait for IDLE; leaves the caller at a falling edge with busy low.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({lcd_e, lcd_rs, lcd_rw, lcd_data} !== 11'h000) begin
            errors++;
            $display("FAIL reset_pins: got e=%b rs=%b rw=%b data=%h, expected all 0", lcd_e, lcd_rs, lcd_rw, lcd_data);
        end
        checks++;
        if ({req0_ready, req1_ready, init_done, busy} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_status: got rdy0=%b rdy1=%b init_done=%b busy=%b, expected 0 0 0 1",
                     req0_ready, req1_ready, init_done, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_e, init_done, busy} !== 3'b001) begin
            errors++;
            $display("FAIL reset_held: got e=%b init_done=%b busy=%b, expected 0 0 1", lcd_e, init_done, busy);
        end
    endtask

    // Releases reset and follows the whole power-on + init sequence.
    // With hold_req set, req0_valid is already high and must stay unserved until IDLE.
    task automatic test_init(input bit hold_req);
        bit prev_e;
        int pulses;
        int width;
        prev_e = 1'b0;
        pulses = 0;
        width  = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 85; k++) begin
            @(negedge clk);
            checks++;
            if (lcd_rw !== 1'b0) begin
                errors++;
                $display("FAIL init_rw k=%0d: got %b expected 0", k, lcd_rw);
            end
            checks++;
            if (init_done !== (k == 85)) begin
                errors++;
                $display("FAIL init_done k=%0d: got %b expected %b", k, init_done, (k == 85));
            end
            if (hold_req) begin
                checks++;
                if (req0_ready !== (k == 85)) begin
                    errors++;
                    $display("FAIL preinit_ready k=%0d: got %b expected %b", k, req0_ready, (k == 85));
                end
            end
            if (lcd_e && !prev_e) begin
                if (pulses < 5) begin
                    checks++;
                    if (k != rise_exp[pulses]) begin
                        errors++;
                        $display("FAIL init_rise%0d: got cycle %0d expected %0d", pulses, k, rise_exp[pulses]);
                    end
                    checks++;
                    if ({lcd_rs, lcd_data} !== {1'b0, init_exp[pulses]}) begin
                        errors++;
                        $display("FAIL init_byte%0d: got rs=%b data=%h expected rs=0 data=%h",
                                 pulses, lcd_rs, lcd_data, init_exp[pulses]);
                    end
                end
                pulses++;
                width = 1;
            end else if (lcd_e) begin
                width++;
            end else if (prev_e) begin
                checks++;
                if (width != 3) begin
                    errors++;
                    $display("FAIL init_width k=%0d: got %0d expected 3", k, width);
                end
            end
            prev_e = lcd_e;
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL init_pulses: got %0d expected 5", pulses);
        end
        if (hold_req) begin
            @(negedge clk);
            checks++;
            if ({busy, lcd_rs, lcd_data} !== {1'b1, 1'b1, 8'h55}) begin
                errors++;
                $display("FAIL preinit_latch: got busy=%b rs=%b data=%h expected 1 1 55", busy, lcd_rs, lcd_data);
            end
            req0_valid = 1'b0;
        end
    endtask

    task automatic test_single_write();
        bit ok;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_idle: got busy=%b expected 0 within bound", busy);
        end
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_grant: got rdy0=%b rdy1=%b expected 1 0", req0_ready, req1_ready);
        end
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            checks++;
            if (lcd_e !== (j >= 3 && j <= 5)) begin
                errors++;
                $display("FAIL single_e T+%0d: got %b expected %b", j, lcd_e, (j >= 3 && j <= 5));
            end
            checks++;
            if ({lcd_rs, lcd_data} !== {1'b1, 8'h41}) begin
                errors++;
                $display("FAIL single_pins T+%0d: got rs=%b data=%h expected 1 41", j, lcd_rs, lcd_data);
            end
            checks++;
            if (busy !== (j != 13)) begin
                errors++;
                $display("FAIL single_busy T+%0d: got %b expected %b", j, busy, (j != 13));
            end
            if (j == 1) req0_valid = 1'b0;
        end
        // Back in IDLE at T+13: a new request is accepted in that same cycle.
        req0_valid = 1'b1; req0_data = 8'h42;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_next_ready: got %b expected 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
    endtask

    task automatic test_long_cmd(input bit rs, input int idle_at);
        bit ok;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL long_idle rs=%b: got busy=%b expected 0 within bound", rs, busy);
        end
        req1_valid = 1'b1; req1_rs = rs; req1_data = 8'h01;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL long_grant rs=%b: got rdy0=%b rdy1=%b expected 0 1", rs, req0_ready, req1_ready);
        end
        for (int j = 1; j <= idle_at; j++) begin
            @(negedge clk);
            if (j == 1) req1_valid = 1'b0;
            checks++;
            if (busy !== (j != idle_at)) begin
                errors++;
                $display("FAIL long_busy rs=%b T+%0d: got %b expected %b", rs, j, busy, (j != idle_at));
            end
            if (j == 4) begin
                checks++;
                if ({lcd_e, lcd_rs, lcd_data} !== {1'b1, rs, 8'h01}) begin
                    errors++;
                    $display("FAIL long_pins rs=%b: got e=%b rs=%b data=%h expected 1 %b 01",
                             rs, lcd_e, lcd_rs, lcd_data, rs);
                end
            end
        end
    endtask

    task automatic test_contention();
        bit ok;
        int ngr;
        int last;
        logic [7:0] exp_dat;
        ngr = 0;
        last = -10;
        exp_dat = 8'h00;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cont_idle: got busy=%b expected 0 within bound", busy);
        end
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h31;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h32;
        #1;
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL cont_both c=%0d: got rdy0=1 rdy1=1 expected at most one", c);
            end
            if (c == last + 1) begin
                checks++;
                if (lcd_data !== exp_dat) begin
                    errors++;
                    $display("FAIL cont_data c=%0d: got %h expected %h", c, lcd_data, exp_dat);
                end
            end
            if (req0_ready || req1_ready) begin
                checks++;
                if ({req0_ready, req1_ready} !== ((ngr % 2 == 0) ? 2'b10 : 2'b01) || c != ngr * 13) begin
                    errors++;
                    $display("FAIL cont_order grant%0d: got rdy0=%b rdy1=%b at c=%0d expected requester %0d at c=%0d",
                             ngr, req0_ready, req1_ready, c, ngr % 2, ngr * 13);
                end
                exp_dat = req0_ready ? 8'h31 : 8'h32;
                last = c;
                ngr++;
            end
            if (ngr == 4 && c > last) break;
        end
        checks++;
        if (ngr != 4) begin
            errors++;
            $display("FAIL cont_count: got %0d grants expected 4", ngr);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // prio points at requester 0 here, yet a lone requester 1 wins every IDLE.
    task automatic test_back_to_back();
        bit ok;
        int ngr;
        ngr = 0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b expected 0 within bound", busy);
        end
        req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h80;
        #1;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) @(negedge clk);
            if (req0_ready || req1_ready) begin
                checks++;
                if ({req0_ready, req1_ready} !== 2'b01 || c != ngr * 13) begin
                    errors++;
                    $display("FAIL b2b_grant%0d: got rdy0=%b rdy1=%b at c=%0d expected 0 1 at c=%0d",
                             ngr, req0_ready, req1_ready, c, ngr * 13);
                end
                ngr++;
                if (ngr == 3) begin
                    @(negedge clk);
                    break;
                end
            end
        end
        checks++;
        if (ngr != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d grants expected 3", ngr);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_midpulse();
        bit ok;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_idle: got busy=%b expected 0 within bound", busy);
        end
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h77;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 1) req0_valid = 1'b0;
        end
        checks++;
        if (lcd_e !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_e: got %b expected 1", lcd_e);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({lcd_e, busy, init_done, lcd_data} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midrst_now: got e=%b busy=%b init_done=%b data=%h expected 0 1 0 00",
                     lcd_e, busy, init_done, lcd_data);
        end
        test_init(1'b0);
    endtask

    task automatic test_preinit();
        rst = 1'b1;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55;
        @(negedge clk);
        test_init(1'b1);
    endtask

    initial begin
        rst        = 1'b0;
        req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
        req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
        #1;
        test_reset();
        test_init(1'b0);
        test_single_write();
        test_long_cmd(1'b0, 28);
        test_long_cmd(1'b1, 13);
        test_contention();
        test_back_to_back();
        test_reset_midpulse();
        test_preinit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Sequences and shares the 8-bit parallel character-LCD bus (data, E, RS, RW) between two requesters, e.g. the CPU peripheral port and the keypad path. After reset it runs the power-on wait and a fixed init command sequence. It then accepts one byte transfer at a time through valid/ready handshakes, using round-robin arbitration. Every transfer is expanded into setup / enable-high / hold / execution-wait phases, so no requester ever drives the LCD pins directly.

## Interface
- PWRON_CYC, 2000000: power-on wait before first init command (≥1)
- SETUP_CYC, 4: cycles RS/data stable with E low before E rises (≥1)
- E_HIGH_CYC, 12: E high pulse width in cycles (≥1)
- HOLD_CYC, 4: cycles data/RS held with E low after E falls (≥1)
- CMD_WAIT_CYC, 2000: execution wait for normal command/data (≥1)
- LONG_WAIT_CYC, 80000: execution wait for clear (0x01) / return home (0x02, 0x03) with RS=0 (≥1)
- CNT_W, 22: phase counter width; must hold the largest of the above
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a byte
- req0_rs  in  1  requester 0 register select (0 command, 1 data)
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  requester 0 transfer accepted this cycle
- req1_valid / req1_rs / req1_data / req1_ready: same as requester 0
- lcd_data  out  8  LCD data bus
- lcd_e  out  1  LCD enable
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write, constant 0 (write only)
- init_done  out  1  init sequence complete, sticky until reset
- busy  out  1  high whenever not (IDLE and init_done)

## Operation
- States: PWRON, SETUP, EHIGH, HOLD, WAIT, IDLE.
- Phase counter: on entry to a timed state it loads N-1 and decrements. The state exits when the counter is 0, so each phase lasts exactly N cycles.
- PWRON lasts PWRON_CYC cycles. It then loads init entry 0 and enters SETUP.
- Init ROM, all RS=0, in order: 0x38, 0x0C, 0x06, 0x01, 0x80.
  - Each entry runs SETUP→EHIGH→HOLD→WAIT.
  - After WAIT, the next entry starts at SETUP.
  - After the WAIT of entry 4, init_done is set and the block enters IDLE.
- Wait length: LONG_WAIT_CYC if RS=0 and byte ∈ {0x01, 0x02, 0x03}; otherwise CMD_WAIT_CYC. Init entry 0x01 uses the long wait.
- Grant in IDLE (combinational ready):
  - reqN_ready = IDLE & init_done & reqN_valid & (prio==N | !req(other)_valid).
  - At most one ready is high in a cycle. Ready is never high outside IDLE or before init_done.
- On a handshake the block:
  - latches rs and data into output registers,
  - sets prio to the other requester,
  - enters SETUP next cycle.
- prio resets to 0. prio changes only on a grant.
- Pin behaviour by state:
  - SETUP: lcd_e=0; lcd_rs/lcd_data show the latched values.
  - EHIGH: lcd_e=1.
  - HOLD and WAIT: lcd_e=0.
  - lcd_data/lcd_rs keep the last transfer value through WAIT and IDLE until the next latch.
- Valid deasserting while not ready has no effect; no request is stored internally.

## Timing
- Reset values (asynchronous, immediate on rst):
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00
  - req0_ready=0, req1_ready=0, init_done=0, busy=1
  - state=PWRON, prio=0
- Reset mid-transfer: E drops at once, the in-flight byte is lost, and the full power-on and init sequence restarts.
- Handshake cycle T (IDLE):
  - SETUP occupies T+1 … T+SETUP_CYC.
  - lcd_e=1 for the next E_HIGH_CYC cycles.
  - HOLD follows, then WAIT.
  - IDLE returns at T+SETUP_CYC+E_HIGH_CYC+HOLD_CYC+wait+1, and the next handshake can occur in that cycle.
- First ready possible at PWRON_CYC + 5·(SETUP_CYC+E_HIGH_CYC+HOLD_CYC) + 4·CMD_WAIT_CYC + LONG_WAIT_CYC cycles after reset release.
- Simultaneous valids: the prio requester wins, and the loser is granted on the next IDLE if it is still valid.
- Continuous single requester: it is granted on every IDLE regardless of prio.

## Test plan
All scenarios use PWRON=10, SETUP=2, E_HIGH=3, HOLD=2, CMD_WAIT=5, LONG_WAIT=20.
- Init: release rst, no valids → lcd_e shows 5 pulses of 3 cycles, latching 0x38, 0x0C, 0x06, 0x01, 0x80 with RS=0. init_done rises 10+5·7+4·5+20=85 cycles after release. lcd_rw is 0 throughout.
- Single data write: req0 sends rs=1, 0x41 at T → lcd_rs=1 and lcd_data=0x41 from T+1, lcd_e high T+3…T+5, next ready possible at T+13.
- Long command: req1 sends rs=0, 0x01 → WAIT lasts 20 cycles; IDLE returns 28 cycles after the handshake. The same byte with rs=1 uses the 5-cycle wait.
- Contention: both valid continuously with 0x31 and 0x32 → grants alternate 0,1,0,1. ready is never high on both requesters in the same cycle.
- Pre-init requests: req0_valid held from reset release → req0_ready stays 0 until init_done. The first grant is in the cycle init_done is first seen high in IDLE.
- Reset mid-pulse: assert rst while lcd_e=1 → lcd_e=0 and busy=1 in the same cycle. After release, PWRON and the init sequence repeat in full.
